// File: rtl/ym_ssg_regs.sv
// CPU-facing register file for the YM2610 SSG section: address/data port decode,
// parallel tone/noise/envelope control fields, readback, write-busy window and envelope restart strobe.
module ym_ssg_regs #(
    parameter int unsigned BUSY_CYCLES = 4
) (
    input  logic        PHI_S,
    input  logic        RESET,
    input  logic        WR,
    input  logic        RD,
    input  logic        A0,
    input  logic [7:0]  DIN,
    output logic [7:0]  DOUT,
    output logic        BUSY,
    output logic [11:0] SSG_FREQ_A,
    output logic [11:0] SSG_FREQ_B,
    output logic [11:0] SSG_FREQ_C,
    output logic [4:0]  SSG_NOISE,
    output logic [5:0]  SSG_EN,
    output logic [4:0]  SSG_VOL_A,
    output logic [4:0]  SSG_VOL_B,
    output logic [4:0]  SSG_VOL_C,
    output logic [15:0] SSG_ENV_FREQ,
    output logic [3:0]  SSG_ENV,
    output logic        ENV_RESTART
);

    localparam int          NUM_REGS    = 14;
    localparam logic [7:0]  BUSY_LOAD   = 8'(BUSY_CYCLES);
    localparam logic [3:0]  REG_MIXER   = 4'h7;
    localparam logic [3:0]  REG_SHAPE   = 4'hD;
    localparam logic [7:0]  MIXER_RESET = 8'h3F;

    // Stored width of each register; bits above it are dropped on write.
    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        case (idx)
            4'h1, 4'h3, 4'h5, 4'hD:  reg_mask = 8'h0F;
            4'h6, 4'h8, 4'h9, 4'hA:  reg_mask = 8'h1F;
            4'h7:                    reg_mask = 8'h3F;
            default:                 reg_mask = 8'hFF;
        endcase
    endfunction

    logic [7:0] addr_q, addr_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];
    logic [7:0] busy_cnt_q, busy_cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       env_restart_q, env_restart_d;

    logic       busy;
    logic       addr_mapped;
    logic       wr_addr;
    logic       wr_data;
    logic       rd_en;

    always_comb begin
        busy        = (busy_cnt_q != 8'd0);
        addr_mapped = (addr_q[7:4] == 4'h0) && (addr_q[3:0] <= REG_SHAPE);
        wr_addr     = WR && !A0;
        wr_data     = WR && A0 && !busy;
        rd_en       = RD && !WR;

        addr_d        = addr_q;
        regs_d        = regs_q;
        busy_cnt_d    = busy ? (busy_cnt_q - 8'd1) : busy_cnt_q;
        dout_d        = dout_q;
        env_restart_d = 1'b0;

        if (wr_addr) begin
            addr_d = DIN;
        end

        // Unmapped data writes still open the busy window.
        if (wr_data) begin
            busy_cnt_d = BUSY_LOAD;
            if (addr_mapped) begin
                regs_d[addr_q[3:0]] = DIN & reg_mask(addr_q[3:0]);
                env_restart_d       = (addr_q[3:0] == REG_SHAPE);
            end
        end

        if (rd_en) begin
            if (!A0) begin
                dout_d = {busy, 7'b0};
            end else if (addr_mapped) begin
                dout_d = regs_q[addr_q[3:0]];
            end else begin
                dout_d = 8'h00;
            end
        end
    end

    always_ff @(posedge PHI_S or posedge RESET) begin
        if (RESET) begin
            addr_q        <= 8'h00;
            busy_cnt_q    <= 8'h00;
            dout_q        <= 8'h00;
            env_restart_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == int'(REG_MIXER)) ? MIXER_RESET : 8'h00;
            end
        end else begin
            addr_q        <= addr_d;
            busy_cnt_q    <= busy_cnt_d;
            dout_q        <= dout_d;
            env_restart_q <= env_restart_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign DOUT         = dout_q;
    assign BUSY         = busy;
    assign ENV_RESTART  = env_restart_q;
    assign SSG_FREQ_A   = {regs_q[1][3:0], regs_q[0]};
    assign SSG_FREQ_B   = {regs_q[3][3:0], regs_q[2]};
    assign SSG_FREQ_C   = {regs_q[5][3:0], regs_q[4]};
    assign SSG_NOISE    = regs_q[6][4:0];
    assign SSG_EN       = regs_q[7][5:0];
    assign SSG_VOL_A    = regs_q[8][4:0];
    assign SSG_VOL_B    = regs_q[9][4:0];
    assign SSG_VOL_C    = regs_q[10][4:0];
    assign SSG_ENV_FREQ = {regs_q[12], regs_q[11]};
    assign SSG_ENV      = regs_q[13][3:0];

endmodule
